// File: rtl/wash_cycle_controller.sv
// Idle/Fill/Wash/Rinse/Spin sequencer with a built-in minute timer and selectable wash+rinse repeats.
// State changes take effect on the clk edge that samples the condition; pause freezes timer and actuators.
module wash_cycle_controller #(
  parameter int TICKS_PER_MIN = 60,
  parameter int TIME_W        = 4,
  parameter int FILL_MIN      = 2,
  parameter int WASH_MIN      = 5,
  parameter int RINSE_MIN     = 2,
  parameter int SPIN_MIN      = 1,
  parameter int MAX_CYCLES    = 3,
  parameter int CYC_W         = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coin_in,
  input  logic [CYC_W-1:0]  cycles_sel,
  input  logic              pause,
  input  logic              abort,
  output logic              wash_done,
  output logic              done_pulse,
  output logic              busy,
  output logic              fill_water_sig,
  output logic              washing_sig,
  output logic              rinse_sig,
  output logic              spin_sig,
  output logic [2:0]        state_code,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [TIME_W-1:0] elapsed_min
);

  localparam int TICK_W = $clog2(TICKS_PER_MIN);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FILL  = 3'b001,
    WASH  = 3'b011,
    RINSE = 3'b010,
    SPIN  = 3'b110
  } state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [CYC_W-1:0]    target;
  logic [CYC_W-1:0]    sel_target;
  logic [TIME_W-1:0]   dur;
  logic                running;
  logic                tick_wrap;
  logic                timeout;
  logic                abort_ok;

  always_comb begin
    case (state)
      FILL:    dur = TIME_W'(FILL_MIN);
      WASH:    dur = TIME_W'(WASH_MIN);
      RINSE:   dur = TIME_W'(RINSE_MIN);
      SPIN:    dur = TIME_W'(SPIN_MIN);
      default: dur = '0;
    endcase
  end

  // Zero repetitions is meaningless, so it runs one; oversize requests clamp.
  always_comb begin
    if (cycles_sel == '0)
      sel_target = CYC_W'(1);
    else if (cycles_sel > CYC_W'(MAX_CYCLES))
      sel_target = CYC_W'(MAX_CYCLES);
    else
      sel_target = cycles_sel;
  end

  assign running   = (state != IDLE) && !pause;
  assign tick_wrap = running && (tick_cnt == TICK_W'(TICKS_PER_MIN - 1));
  assign timeout   = tick_wrap && (elapsed_min == dur - TIME_W'(1));
  assign abort_ok  = abort && (state == FILL || state == WASH || state == RINSE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      elapsed_min <= '0;
      cycle_count <= '0;
      target      <= '0;
      done_pulse  <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (abort_ok) begin
        state       <= SPIN;
        tick_cnt    <= '0;
        elapsed_min <= '0;
      end else if (state == IDLE) begin
        tick_cnt    <= '0;
        elapsed_min <= '0;
        if (coin_in) begin
          state       <= FILL;
          target      <= sel_target;
          cycle_count <= '0;
        end
      end else if (timeout) begin
        tick_cnt    <= '0;
        elapsed_min <= '0;
        case (state)
          FILL: state <= WASH;
          WASH: state <= RINSE;
          RINSE: begin
            cycle_count <= cycle_count + CYC_W'(1);
            if (({1'b0, cycle_count} + (CYC_W+1)'(1)) < {1'b0, target})
              state <= WASH;
            else
              state <= SPIN;
          end
          SPIN: begin
            state      <= IDLE;
            done_pulse <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (tick_wrap) begin
        tick_cnt    <= '0;
        elapsed_min <= elapsed_min + TIME_W'(1);
      end else if (running) begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  assign state_code     = state;
  assign wash_done      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign fill_water_sig = (state == FILL)  && !pause;
  assign washing_sig    = (state == WASH)  && !pause;
  assign rinse_sig      = (state == RINSE) && !pause;
  assign spin_sig       = (state == SPIN)  && !pause;

endmodule
